ready_pack: RTL and testbench

READY_PACK -- requirements
Module: ready_pack

---
 rtl/ready_pack.sv | 111 +++++++++++
 tb/tb_ready_pack.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ready_pack.sv
// rtl/ready_pack.sv - packs RATIO source words into one wide word with a registered ready/valid handshake.
// Optional partial-group flush is built when READY_PACK_FLUSH_EN is defined.
module ready_pack #(
    parameter int WIDTH = 16,
    parameter int RATIO = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic [WIDTH-1:0]              dat_i,
    output logic                          ready_i,
    output logic                          valid_o,
    output logic [WIDTH*RATIO-1:0]        dat_o,
    output logic [$clog2(RATIO+1)-1:0]    lanes_o,
`ifdef READY_PACK_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic                          ready_o
);

    localparam int LW = $clog2(RATIO + 1);
    localparam int AW = WIDTH * RATIO;
    localparam logic [LW-1:0] FULL = LW'(RATIO);

    logic [LW-1:0] cnt_q, cnt_d, cnt_acc;
    logic [AW-1:0] acc_q, acc_d, acc_new;
    logic [AW-1:0] dat_q, dat_d;
    logic [LW-1:0] lanes_q, lanes_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic          in_xfer, out_xfer, slot_free;
    logic          pend, pend_d, emit;

`ifdef READY_PACK_FLUSH_EN
    logic          flush_pend_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= pend_d;
        end
    end
`endif

    always_comb begin
        in_xfer   = valid_i & ready_q;
        out_xfer  = valid_q & ready_o;
        slot_free = !valid_q | ready_o;
        cnt_acc   = cnt_q + {{(LW-1){1'b0}}, in_xfer};

        // ready_q is only high while cnt_q < RATIO, so at most one lane matches
        acc_new = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (in_xfer && (cnt_q == LW'(k))) begin
                acc_new[k*WIDTH +: WIDTH] = dat_i;
            end
        end

`ifdef READY_PACK_FLUSH_EN
        pend = flush_pend_q | (flush_i & (cnt_acc != '0));
`else
        pend = 1'b0;
`endif

        emit = slot_free & (cnt_acc != '0) & ((cnt_acc == FULL) | pend);

        cnt_d   = cnt_acc;
        acc_d   = acc_new;
        valid_d = valid_q & !out_xfer;
        dat_d   = dat_q;
        lanes_d = lanes_q;
        pend_d  = pend;

        if (emit) begin
            // accumulator is zeroed after every emit, so unused lanes of a partial group are zero
            dat_d   = acc_new;
            lanes_d = cnt_acc;
            valid_d = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            pend_d  = 1'b0;
        end

        ready_d = (cnt_d != FULL) & !pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            dat_q   <= '0;
            lanes_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dat_q   <= dat_d;
            lanes_q <= lanes_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_i = ready_q;
    assign valid_o = valid_q;
    assign dat_o   = dat_q;
    assign lanes_o = lanes_q;

endmodule

// File: tb/tb_ready_pack.sv
// tb/tb_ready_pack.sv - self-checking bench for ready_pack with a word-queue reference model.
module tb_ready_pack;

    localparam int W  = 16;
    localparam int R  = 4;
    localparam int LW = $clog2(R + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_i;
    logic [W-1:0]    dat_i;
    logic            ready_i;
    logic            valid_o;
    logic [W*R-1:0]  dat_o;
    logic [LW-1:0]   lanes_o;
    logic            flush_i;
    logic            ready_o;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    bit flush_mode = 0;
    logic [W-1:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_timeout(input string tag, input int cyc, input int limit);
        total++;
        if (cyc >= limit) begin
            bad++;
            $error("FAIL %s wait expired after %0d cycles", tag, cyc);
        end
    endtask

    ready_pack #(.WIDTH(W), .RATIO(R)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .dat_i   (dat_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .dat_o   (dat_o),
        .lanes_o (lanes_o),
`ifdef READY_PACK_FLUSH_EN
        .flush_i (flush_i),
`endif
        .ready_o (ready_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        logic            acc, out, rs;
        logic [W*R-1:0]  od, ex;
        logic [LW-1:0]   ol;
        logic [W-1:0]    di;
        int              n;
        rs  = rst_n;
        acc = valid_i & ready_i;
        out = valid_o & ready_o;
        od  = dat_o;
        ol  = lanes_o;
        di  = dat_i;
        @(posedge clk);
        #1;
        if (rs) begin
            if (out) begin
                out_cnt++;
                n = R;
                if (flush_mode && q.size() < R) n = q.size();
                ex = '0;
                for (int i = 0; i < n; i++) begin
                    if (q.size() > 0) ex[i*W +: W] = q.pop_front();
                end
                chk("out_lanes", 64'(ol), 64'(n));
                chk("out_data", 64'(od), 64'(ex));
            end
            if (acc) begin
                q.push_back(di);
                acc_cnt++;
            end
        end
    endtask

    initial begin
        logic [W*R-1:0] held;
        int a0, o0, cyc, rlow;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        dat_i   = '0;
        flush_i = 1'b0;
        ready_o = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_ready", 64'(ready_i), 64'(0));
        chk("rst_lanes", 64'(lanes_o), 64'(0));
        chk("rst_dat", 64'(dat_o), 64'h0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'(ready_i), 64'(1));

        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1;
            dat_i   = W'(i);
            step();
        end
        valid_i = 1'b0;
        chk("pack4_valid", 64'(valid_o), 64'(1));
        chk("pack4_dat", 64'(dat_o), 64'h0004_0003_0002_0001);
        chk("pack4_lanes", 64'(lanes_o), 64'(4));
        step();

        o0 = out_cnt;
        rlow = 0;
        for (int i = 0; i < 12; i++) begin
            valid_i = 1'b1;
            dat_i   = W'($urandom);
            if (!ready_i) rlow++;
            step();
        end
        valid_i = 1'b0;
        step();
        step();
        chk("burst12_outputs", 64'(out_cnt - o0), 64'(3));
        chk("burst12_ready_low", 64'(rlow), 64'(0));
        chk("burst12_queue", 64'(q.size()), 64'(0));

        ready_o = 1'b0;
        a0 = acc_cnt;
        o0 = out_cnt;
        cyc = 0;
        while (acc_cnt - a0 < 8 && cyc < 40) begin
            valid_i = 1'b1;
            dat_i   = W'(16'h0100 + (acc_cnt - a0));
            step();
            cyc++;
        end
        valid_i = 1'b0;
        chk_timeout("bp_wait", cyc, 40);
        chk("bp_accepted", 64'(acc_cnt - a0), 64'(8));
        chk("bp_ready_low", 64'(ready_i), 64'(0));
        chk("bp_valid", 64'(valid_o), 64'(1));
        chk("bp_first_word", 64'(dat_o), 64'h0103_0102_0101_0100);
        held = dat_o;
        step();
        step();
        chk("bp_hold_dat", 64'(dat_o), 64'(held));
        chk("bp_hold_valid", 64'(valid_o), 64'(1));
        ready_o = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("bp_outputs", 64'(out_cnt - o0), 64'(2));
        chk("bp_queue", 64'(q.size()), 64'(0));
        chk("bp_ready_back", 64'(ready_i), 64'(1));

        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1;
            dat_i   = W'(16'h00E0 + i);
            step();
        end
        valid_i = 1'b0;
        rst_n = 1'b0;
        step();
        q.delete();
        chk("midrst_valid", 64'(valid_o), 64'(0));
        chk("midrst_ready", 64'(ready_i), 64'(0));
        rst_n = 1'b1;
        step();
        chk("midrst_ready_back", 64'(ready_i), 64'(1));
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1;
            dat_i   = W'(16'h0010 + i);
            step();
        end
        valid_i = 1'b0;
        chk("midrst_fresh", 64'(dat_o), 64'h0014_0013_0012_0011);
        step();
        chk("midrst_queue", 64'(q.size()), 64'(0));

        a0 = acc_cnt;
        o0 = out_cnt;
        cyc = 0;
        while (acc_cnt - a0 < 1000 && cyc < 20000) begin
            valid_i = 1'($urandom_range(0, 1));
            dat_i   = W'($urandom);
            ready_o = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        valid_i = 1'b0;
        ready_o = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk_timeout("rand_wait", cyc, 20000);
        chk("rand_accepted", 64'(acc_cnt - a0), 64'(1000));
        chk("rand_outputs", 64'(out_cnt - o0), 64'(250));
        chk("rand_queue", 64'(q.size()), 64'(0));

`ifdef READY_PACK_FLUSH_EN
        flush_mode = 1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_empty", 64'(valid_o), 64'(0));
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            dat_i   = W'(16'h000A + i);
            step();
        end
        valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_valid", 64'(valid_o), 64'(1));
        chk("flush_dat", 64'(dat_o), 64'h0000_000C_000B_000A);
        chk("flush_lanes", 64'(lanes_o), 64'(3));
        step();
        step();
        chk("flush_ready", 64'(ready_i), 64'(1));
        chk("flush_queue", 64'(q.size()), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
